// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: turns the 4-bit DIR command into left/right H-bridge drive
// (one PWM pin plus forward/reverse enables per wheel). Each wheel's duty slews
// toward a target and polarity reversals pass through a dead time with both
// enables low.
// Optional feature macro: SOFT_RAMP_EN. When defined, duty moves RAMP_STEP per
// ramp tick (one tick every RAMP_DIV cycles). When undefined, duty jumps to its
// goal on the next cycle; the dead time on reversal is kept either way.
module motor_drive_ctrl #(
  parameter int PWM_PERIOD = 1000,
  parameter int FULL_DUTY  = 1000,
  parameter int VEER_DUTY  = 600,
  parameter int PIVOT_DUTY = 700,
  parameter int RAMP_DIV   = 5000,
  parameter int RAMP_STEP  = 10,
  parameter int DEADTIME   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dir_code,
  input  logic       direction,
  output logic       l_pwm,
  output logic       l_fwd,
  output logic       l_rev,
  output logic       r_pwm,
  output logic       r_fwd,
  output logic       r_rev,
  output logic       moving
);
  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int NW = 2;  // wheel 0 = left, wheel 1 = right
  localparam logic POL_FWD = 1'b0;
  localparam logic POL_REV = 1'b1;
  localparam logic [DW-1:0] FULL_D   = DW'(FULL_DUTY);
  localparam logic [DW-1:0] VEER_D   = DW'(VEER_DUTY);
  localparam logic [DW-1:0] PIVOT_D  = DW'(PIVOT_DUTY);
  localparam logic [DW-1:0] LAST_CNT = DW'(PWM_PERIOD - 1);

  typedef struct packed {
    logic [DW-1:0] duty;
    logic          pol;
  } tgt_t;

  logic [DW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic          pwm_wrap;
  logic          moving_q, moving_d;
  tgt_t          fl, fr;
  tgt_t [NW-1:0] tgt;

  logic [NW-1:0]         pwm, fwd, rev;
  logic [NW-1:0][DW-1:0] cur_duty;

  // Shared PWM carrier counter, 0..PWM_PERIOD-1
  always_comb begin
    pwm_wrap  = (pwm_cnt_q == LAST_CNT);
    pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
  end

`ifdef SOFT_RAMP_EN
  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic          ramp_tick;

  // Free-running ramp divider; tick is its terminal count
  always_comb begin
    ramp_tick  = (ramp_cnt_q == RAMP_LAST);
    ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + 1'b1;
  end

  // Ramp divider register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ramp_cnt_q <= '0;
    else      ramp_cnt_q <= ramp_cnt_d;
  end
`endif

  // Target table: forward-motion L/R targets, then mirrored and inverted when backing up
  always_comb begin
    fl = '{duty: '0, pol: POL_FWD};
    fr = '{duty: '0, pol: POL_FWD};
    case (dir_code)
      4'b0000: begin fl.duty = FULL_D;  fr.duty = FULL_D;  end  // PROCEED
      4'b1001: begin fl.duty = FULL_D;  fr.duty = VEER_D;  end  // VEER_R
      4'b1010: begin fl.duty = FULL_D;                     end  // HARD_R
      4'b1011: begin fl.duty = PIVOT_D; fr.duty = PIVOT_D; fr.pol = POL_REV; end  // NINETY_R
      4'b0101: begin fl.duty = VEER_D;  fr.duty = FULL_D;  end  // VEER_L
      4'b0110: begin                    fr.duty = FULL_D;  end  // HARD_L
      4'b0111: begin fl.duty = PIVOT_D; fl.pol = POL_REV; fr.duty = PIVOT_D; end  // NINETY_L
      default: ;                                                // STOP / undefined
    endcase
    if (direction) begin
      tgt[0] = fl;
      tgt[1] = fr;
    end else begin
      tgt[0] = '{duty: fr.duty, pol: ~fr.pol};
      tgt[1] = '{duty: fl.duty, pol: ~fl.pol};
    end
  end

  for (genvar w = 0; w < NW; w++) begin : g_wheel
    motor_drive_wheel #(
      .DW       (DW),
      .RAMP_STEP(RAMP_STEP),
      .DEADTIME (DEADTIME)
    ) u_wheel (
      .clk     (clk),
      .rst     (rst),
`ifdef SOFT_RAMP_EN
      .tick    (ramp_tick),
`endif
      .pwm_cnt (pwm_cnt_q),
      .pwm_wrap(pwm_wrap),
      .tgt_duty(tgt[w].duty),
      .tgt_pol (tgt[w].pol),
      .pwm     (pwm[w]),
      .fwd     (fwd[w]),
      .rev     (rev[w]),
      .cur_duty(cur_duty[w])
    );
  end

  // Either wheel carrying non-zero duty counts as moving
  always_comb moving_d = |{cur_duty[0], cur_duty[1]};

  // Carrier counter and moving flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q <= '0;
      moving_q  <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      moving_q  <= moving_d;
    end
  end

  assign l_pwm  = pwm[0];
  assign l_fwd  = fwd[0];
  assign l_rev  = rev[0];
  assign r_pwm  = pwm[1];
  assign r_fwd  = fwd[1];
  assign r_rev  = rev[1];
  assign moving = moving_q;

endmodule

// motor_drive_wheel: one H-bridge channel. RUN slews duty toward the goal;
// a polarity change first drains duty to 0, then holds DEAD for DEADTIME
// cycles with both enables low before adopting the new polarity.
module motor_drive_wheel #(
  parameter int DW        = 10,
  parameter int RAMP_STEP = 10,
  parameter int DEADTIME  = 50000
) (
  input  logic          clk,
  input  logic          rst,
`ifdef SOFT_RAMP_EN
  input  logic          tick,
`endif
  input  logic [DW-1:0] pwm_cnt,
  input  logic          pwm_wrap,
  input  logic [DW-1:0] tgt_duty,
  input  logic          tgt_pol,
  output logic          pwm,
  output logic          fwd,
  output logic          rev,
  output logic [DW-1:0] cur_duty
);
  localparam int CW = $clog2(DEADTIME + 1);
  localparam logic [CW-1:0] DEAD_LOAD = CW'(DEADTIME - 1);
  localparam logic [DW-1:0] STEP_D    = DW'(RAMP_STEP);

  typedef enum logic {RUN = 1'b0, DEAD = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] dead_cnt_q, dead_cnt_d;
  logic [DW-1:0] cur_duty_q, cur_duty_d;
  logic [DW-1:0] applied_q, applied_d;
  logic [DW-1:0] goal;
  logic          cur_pol_q, cur_pol_d, eff_pol;
  logic          pwm_q, pwm_d, fwd_q, fwd_d, rev_q, rev_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      dead_cnt_q <= '0;
      cur_duty_q <= '0;
      cur_pol_q  <= 1'b0;
      applied_q  <= '0;
      pwm_q      <= 1'b0;
      fwd_q      <= 1'b0;
      rev_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      cur_duty_q <= cur_duty_d;
      cur_pol_q  <= cur_pol_d;
      applied_q  <= applied_d;
      pwm_q      <= pwm_d;
      fwd_q      <= fwd_d;
      rev_q      <= rev_d;
    end
  end

  // Next state: reversal sequencing, polarity latch, duty slew, period-aligned duty update
  always_comb begin
    // a zero-duty target never asks for a reversal
    eff_pol    = (tgt_duty == '0) ? cur_pol_q : tgt_pol;
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    cur_pol_d  = cur_pol_q;
    goal       = '0;
    case (state_q)
      RUN: begin
        goal = (eff_pol == cur_pol_q) ? tgt_duty : '0;
        if ((eff_pol != cur_pol_q) && (cur_duty_q == '0)) begin
          state_d    = DEAD;
          dead_cnt_d = DEAD_LOAD;
        end
      end
      DEAD: begin
        if (dead_cnt_q == '0) begin
          state_d   = RUN;
          cur_pol_d = eff_pol;
        end else begin
          dead_cnt_d = dead_cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
`ifdef SOFT_RAMP_EN
    cur_duty_d = cur_duty_q;
    if (tick) begin
      if (goal > cur_duty_q)
        cur_duty_d = ((goal - cur_duty_q) > STEP_D) ? cur_duty_q + STEP_D : goal;
      else if (goal < cur_duty_q)
        cur_duty_d = ((cur_duty_q - goal) > STEP_D) ? cur_duty_q - STEP_D : goal;
    end
`else
    cur_duty_d = goal;
`endif
    // only take a new duty at the period boundary so no pulse is truncated
    applied_d = pwm_wrap ? cur_duty_q : applied_q;
  end

  // Output decode: PWM compare and exclusive polarity enables, all gated off in DEAD
  always_comb begin
    pwm_d = (state_q == RUN) && (pwm_cnt < applied_q);
    fwd_d = (state_q == RUN) && !cur_pol_q && (cur_duty_q != '0);
    rev_d = (state_q == RUN) &&  cur_pol_q && (cur_duty_q != '0);
  end

  assign pwm      = pwm_q;
  assign fwd      = fwd_q;
  assign rev      = rev_q;
  assign cur_duty = cur_duty_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Directed bench for motor_drive_ctrl with small parameters
// (period 16, full 16, veer 8, pivot 12, ramp div 4, ramp step 4, dead time 10).
// Expected cycle positions are worked out by hand for both build variants.
module tb_motor_drive_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dir_code = 4'b1111;
  logic       direction = 1'b1;
  logic       l_pwm, l_fwd, l_rev, r_pwm, r_fwd, r_rev, moving;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  motor_drive_ctrl #(
    .PWM_PERIOD(16), .FULL_DUTY(16), .VEER_DUTY(8), .PIVOT_DUTY(12),
    .RAMP_DIV(4), .RAMP_STEP(4), .DEADTIME(10)
  ) dut (
    .clk(clk), .rst(rst), .dir_code(dir_code), .direction(direction),
    .l_pwm(l_pwm), .l_fwd(l_fwd), .l_rev(l_rev),
    .r_pwm(r_pwm), .r_fwd(r_fwd), .r_rev(r_rev), .moving(moving)
  );

  // advance n cycles, ending on a falling edge
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  // high-cycle count of each PWM pin over one full period
  task automatic count_pwm(output int lc, output int rc);
    lc = 0; rc = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      lc += int'(l_pwm);
      rc += int'(r_pwm);
    end
  endtask

  // after a command: first cycle each fwd pin is low and each rev pin is high
  task automatic scan_rev(input bit want_l, input bit want_r,
                          output int lf, output int lr, output int rf, output int rr,
                          output bit ovl);
    lf = -1; lr = -1; rf = -1; rr = -1; ovl = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step(1);
      if (lf < 0 && !l_fwd) lf = k;
      if (rf < 0 && !r_fwd) rf = k;
      if (lr < 0 && l_rev) lr = k;
      if (rr < 0 && r_rev) rr = k;
      if ((l_fwd && l_rev) || (r_fwd && r_rev)) ovl = 1'b1;
      if ((!want_l || lr > 0) && (!want_r || rr > 0)) break;
    end
  endtask

  task automatic test_reset;
    int bad;
    #1 rst = 1'b0;
    #2;
    n_chk++;
    if ({l_pwm, l_fwd, l_rev, r_pwm, r_fwd, r_rev, moving} !== 7'b0)
      $display("FAIL reset_outputs: got %b want 0000000",
               {l_pwm, l_fwd, l_rev, r_pwm, r_fwd, r_rev, moving});
    else n_pass++;
    step(3);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if ({l_pwm, l_fwd, l_rev, r_pwm, r_fwd, r_rev, moving} !== 7'b0) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL stop_idle: got %0d non-zero cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_proceed;
    int k_on, lc, rc;
    dir_code = 4'b0000; direction = 1'b1;
    k_on = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (l_fwd && r_fwd) begin k_on = k; break; end
    end
    n_chk++;
`ifdef SOFT_RAMP_EN
    if (k_on < 2 || k_on > 5) $display("FAIL proceed_fwd_rise: got cycle %0d want 2..5", k_on);
`else
    if (k_on != 2) $display("FAIL proceed_fwd_rise: got cycle %0d want 2", k_on);
`endif
    else n_pass++;
    n_chk++;
    if (moving !== 1'b1) $display("FAIL proceed_moving: got %b want 1", moving);
    else n_pass++;
    step(40);
    count_pwm(lc, rc);
    n_chk++;
    if (lc != 16 || rc != 16) $display("FAIL proceed_full_pwm: got l=%0d r=%0d want 16/16", lc, rc);
    else n_pass++;
    n_chk++;
    if ({l_fwd, l_rev, r_fwd, r_rev} !== 4'b1010)
      $display("FAIL proceed_pol: got %b want 1010", {l_fwd, l_rev, r_fwd, r_rev});
    else n_pass++;
  endtask

  task automatic test_ninety_r;
    int lf, lr, rf, rr, lc, rc;
    bit ovl;
    dir_code = 4'b1011;
    scan_rev(1'b0, 1'b1, lf, lr, rf, rr, ovl);
    n_chk++;
`ifdef SOFT_RAMP_EN
    if (rr < 0 || rf < 0 || (rr - rf) < 12)
      $display("FAIL ninety_r_dead: got fall=%0d rise=%0d want gap>=12", rf, rr);
`else
    if (rf != 2 || rr != 14)
      $display("FAIL ninety_r_dead: got fall=%0d rise=%0d want 2/14", rf, rr);
`endif
    else n_pass++;
    n_chk++;
    if (ovl || lf != -1) $display("FAIL ninety_r_left: got overlap=%0d l_fwd_drop=%0d want 0/-1", ovl, lf);
    else n_pass++;
    step(40);
    count_pwm(lc, rc);
    n_chk++;
    if (lc != 12 || rc != 12) $display("FAIL ninety_r_pwm: got l=%0d r=%0d want 12/12", lc, rc);
    else n_pass++;
    n_chk++;
    if ({l_fwd, l_rev, r_fwd, r_rev} !== 4'b1001)
      $display("FAIL ninety_r_pol: got %b want 1001", {l_fwd, l_rev, r_fwd, r_rev});
    else n_pass++;
  endtask

  task automatic test_reverse;
    int lf, lr, rf, rr, lc, rc;
    bit ovl;
    dir_code = 4'b0000; direction = 1'b1;
    step(60);
    n_chk++;
    if ({l_fwd, l_rev, r_fwd, r_rev} !== 4'b1010)
      $display("FAIL reverse_pre: got %b want 1010", {l_fwd, l_rev, r_fwd, r_rev});
    else n_pass++;
    dir_code = 4'b0101; direction = 1'b0;
    scan_rev(1'b1, 1'b1, lf, lr, rf, rr, ovl);
    n_chk++;
`ifdef SOFT_RAMP_EN
    if (lr < 0 || lf < 0 || (lr - lf) < 12)
      $display("FAIL reverse_l_dead: got fall=%0d rise=%0d want gap>=12", lf, lr);
`else
    if (lf != 2 || lr != 14)
      $display("FAIL reverse_l_dead: got fall=%0d rise=%0d want 2/14", lf, lr);
`endif
    else n_pass++;
    n_chk++;
`ifdef SOFT_RAMP_EN
    if (rr < 0 || rf < 0 || (rr - rf) < 12)
      $display("FAIL reverse_r_dead: got fall=%0d rise=%0d want gap>=12", rf, rr);
`else
    if (rf != 2 || rr != 14)
      $display("FAIL reverse_r_dead: got fall=%0d rise=%0d want 2/14", rf, rr);
`endif
    else n_pass++;
    n_chk++;
    if (ovl) $display("FAIL reverse_overlap: got fwd&rev=1 want never");
    else n_pass++;
    step(40);
    count_pwm(lc, rc);
    n_chk++;
    if (lc != 16 || rc != 8) $display("FAIL reverse_pwm: got l=%0d r=%0d want 16/8", lc, rc);
    else n_pass++;
    n_chk++;
    if ({l_fwd, l_rev, r_fwd, r_rev} !== 4'b0101)
      $display("FAIL reverse_pol: got %b want 0101", {l_fwd, l_rev, r_fwd, r_rev});
    else n_pass++;
  endtask

  task automatic test_undefined;
    int mf, lc, rc, bad;
    dir_code = 4'b0010; direction = 1'b1;
    mf = -1;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (!moving) begin mf = k; break; end
    end
    n_chk++;
`ifdef SOFT_RAMP_EN
    if (mf < 2) $display("FAIL undef_moving_fall: got cycle %0d want >=2", mf);
`else
    if (mf != 2) $display("FAIL undef_moving_fall: got cycle %0d want 2", mf);
`endif
    else n_pass++;
    n_chk++;
    if ({l_fwd, l_rev, r_fwd, r_rev} !== 4'b0000)
      $display("FAIL undef_pol_with_moving: got %b want 0000", {l_fwd, l_rev, r_fwd, r_rev});
    else n_pass++;
    step(30);
    bad = 0;
    count_pwm(lc, rc);
    if ({l_fwd, l_rev, r_fwd, r_rev, moving} !== 5'b0) bad++;
    n_chk++;
    if (lc != 0 || rc != 0 || bad != 0)
      $display("FAIL undef_idle: got l=%0d r=%0d pinbad=%0d want 0/0/0", lc, rc, bad);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    int k_on;
    dir_code = 4'b0000; direction = 1'b1;
    step(18);
    n_chk++;
    if (l_fwd !== 1'b1) $display("FAIL midrst_pre: got l_fwd=%b want 1", l_fwd);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({l_pwm, l_fwd, l_rev, r_pwm, r_fwd, r_rev, moving} !== 7'b0)
      $display("FAIL midrst_async: got %b want 0000000",
               {l_pwm, l_fwd, l_rev, r_pwm, r_fwd, r_rev, moving});
    else n_pass++;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    k_on = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (l_fwd && r_fwd) begin k_on = k; break; end
    end
    n_chk++;
`ifdef SOFT_RAMP_EN
    if (k_on != 5) $display("FAIL midrst_restart: got cycle %0d want 5", k_on);
`else
    if (k_on != 2) $display("FAIL midrst_restart: got cycle %0d want 2", k_on);
`endif
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_proceed;
    test_ninety_r;
    test_reverse;
    test_undefined;
    test_mid_reset;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
